// File: rtl/alu_multicycle.sv
// EX-stage execution unit: single-cycle ALU ops plus a WIDTH-iteration shift-add multiply,
// with a valid/ready handshake so the pipeline can stall while a multiply is in flight.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [3:0]       ALUCtrl_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic [SHW-1:0]   r_count;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [SHW-1:0]   w_shamt;
  logic             w_is_mul;
  logic             w_mul_last;

  assign w_shamt    = data2_i[SHW-1:0];
  assign w_is_mul   = (ALUCtrl_i == 4'b0101);
  assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_last = (r_count == SHW'(WIDTH - 1));

  // Single-cycle result; MUL and reserved codes yield zero here.
  always_comb begin
    w_alu = '0;
    case (ALUCtrl_i)
      4'b0000: w_alu = data1_i & data2_i;
      4'b0001: w_alu = data1_i ^ data2_i;
      4'b0010: w_alu = data1_i << w_shamt;
      4'b0011: w_alu = data1_i + data2_i;
      4'b0100: w_alu = data1_i - data2_i;
      4'b0110: w_alu = data1_i + data2_i;
      4'b0111: w_alu = WIDTH'($signed(data1_i) >>> w_shamt);
      4'b1000: w_alu = data1_i + data2_i;
      4'b1001: w_alu = data1_i + data2_i;
      4'b1010: w_alu = data1_i - data2_i;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (valid_i) w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
      S_BUSY:  if (w_mul_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: result capture and shift-add multiply iteration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_zero   <= 1'b1;
    end else if (r_state == S_IDLE && valid_i) begin
      if (w_is_mul) begin
        r_mcand  <= data1_i;
        r_mplier <= data2_i;
        r_acc    <= '0;
        r_count  <= '0;
      end else begin
        r_data <= w_alu;
        r_zero <= (w_alu == '0);
      end
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + SHW'(1);
      if (w_mul_last) begin
        r_data <= w_acc_nxt;
        r_zero <= (w_acc_nxt == '0);
      end
    end
  end

  assign ready_o = (r_state == S_IDLE);
  assign valid_o = (r_state == S_DONE);
  assign data_o  = r_data;
  assign zero_o  = r_zero;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32).
module tb_alu_multicycle;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic [3:0]  ALUCtrl_i = '0;
  logic [31:0] data_o;
  logic        zero_o;
  logic        valid_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_multicycle #(.WIDTH(32)) u_dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data_o    (data_o),
    .zero_o    (zero_o),
    .valid_o   (valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for completion, check result, zero flag, latency and pulse width.
  // With hold set, an ADD request stays on valid_i while the operation is in flight.
  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit hold);
    int          lat;
    logic [31:0] prev;
    @(negedge clk_i);
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    prev      = data_o;
    ALUCtrl_i = ctrl;
    data1_i   = a;
    data2_i   = b;
    valid_i   = 1'b1;
    @(posedge clk_i);
    #1;
    if (hold) begin
      ALUCtrl_i = 4'b0011;
      data1_i   = 32'd5;
      data2_i   = 32'd7;
    end else begin
      valid_i = 1'b0;
      data1_i = 32'hDEAD_BEEF;
      data2_i = 32'h1234_5678;
    end
    lat = 1;
    while (!valid_o && lat < 100) begin
      if (hold && lat == 16) begin
        check({tag, "_busy_hold"}, data_o, prev);
        check({tag, "_busy_ready"}, 32'(ready_o), 32'd0);
      end
      @(posedge clk_i);
      #1;
      lat++;
    end
    valid_i = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, data_o, exp);
    check({tag, "_zero"}, 32'(zero_o), 32'(exp == 32'd0));
    @(posedge clk_i);
    #1;
    check({tag, "_pulse_end"}, 32'(valid_o), 32'd0);
    check({tag, "_data_hold"}, data_o, exp);
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_data", data_o, 32'd0);
    check("rst_zero", 32'(zero_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);

    run_op("add",  4'b0011, 32'd5, 32'd7, 32'd12, 1, 1'b0);
    run_op("addi", 4'b0110, 32'd5, 32'd7, 32'd12, 1, 1'b0);
    run_op("lw",   4'b1000, 32'd5, 32'd7, 32'd12, 1, 1'b0);
    run_op("sw",   4'b1001, 32'd5, 32'd7, 32'd12, 1, 1'b0);
    run_op("beq",  4'b1010, 32'h1234, 32'h1234, 32'd0, 1, 1'b0);
    run_op("sub",  4'b0100, 32'd3, 32'd5, 32'hFFFF_FFFE, 1, 1'b0);
    run_op("srai", 4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 1'b0);
    run_op("sll",  4'b0010, 32'd1, 32'd31, 32'h8000_0000, 1, 1'b0);
    run_op("and",  4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1, 1'b0);
    run_op("rsvd", 4'b1111, 32'd5, 32'd7, 32'd0, 1, 1'b0);

    run_op("mul_neg", 4'b0101, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33, 1'b1);
    run_op("mul_ovf", 4'b0101, 32'h0001_0000, 32'h0001_0000, 32'd0, 33, 1'b0);
    run_op("mul_dec", 4'b0101, 32'd1234, 32'd5678, 32'd7006652, 33, 1'b0);

    // Reset in the middle of a multiply: the operation is discarded.
    @(negedge clk_i);
    ALUCtrl_i = 4'b0101;
    data1_i   = 32'd1234;
    data2_i   = 32'd5678;
    valid_i   = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_data", data_o, 32'd0);
    check("midrst_zero", 32'(zero_o), 32'd1);
    check("midrst_valid", 32'(valid_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    check("midrst_no_pulse", 32'(seen), 32'd0);
    check("midrst_data_after", data_o, 32'd0);

    run_op("xor", 4'b0001, 32'h0000_F0F0, 32'h0000_FFFF, 32'h0000_0F0F, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
